pa_mc: RTL and testbench
========================

Name: pa_mc

Overview:
- Multi-channel, parametrised phase accumulator for the DDFS datapath.
- Generalises the single-channel `pa` to NCH independent channels.
- Each channel has its own frequency control word (FCW) and phase offset word (POW).
- Configuration uses a valid/ready handshake into shadow registers. Shadow values commit phase-continuously at the channel's wrap.
- Per-channel truncated phases feed the sine LUT stage.

Parameters:
- NBIT, 12, accumulator and FCW/POW width.
- OBIT, 10, output phase width after truncation (1 <= OBIT <= NBIT).
- NCH, 4, number of channels (NCH >= 2). Localparam CHW = $clog2(NCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance all accumulators when high.
- sync  in  1  synchronous clear of all accumulators (phase alignment).
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  block can accept a config word.
- cfg_ch  in  CHW  target channel.
- fcw_in  in  NBIT  frequency control word.
- pow_in  in  NBIT  phase offset word.
- pa_out  out  NCH*OBIT  packed phases; channel c occupies bits [c*OBIT +: OBIT].
- wrap  out  NCH  per-channel overflow pulse.

Behaviour:
- Reset (async assert, sync release):
  - acc, active fcw/pow, shadow fcw/pow and pending all = 0.
  - pa_out = 0, wrap = 0, cfg_ready = 1.
- Transfer:
  - A transfer occurs on a cycle with cfg_valid && cfg_ready.
  - It writes shadow_fcw[cfg_ch] = fcw_in and shadow_pow[cfg_ch] = pow_in, and sets pending[cfg_ch] at the edge.
  - cfg_ch >= NCH: the transfer is accepted and dropped, and no pending flag is set.
- cfg_ready:
  - Registered; equals ~|pending.
  - Only one channel update is outstanding at a time.
  - A transfer drops cfg_ready on the next cycle.
  - cfg_ready returns high on the cycle after commit.
- Accumulate, per channel c, each cycle:
  - If sync: acc[c] <= 0 and wrap[c] <= 0.
  - Else if en: {carry, acc[c]} <= acc[c] + fcw[c] (mod 2^NBIT), and wrap[c] <= carry.
  - Else: hold, and wrap[c] <= 0.
  - sync has priority over en.
- Commit:
  - Condition on a cycle where pending[c] = 1 (flag already registered): carry[c] && en && !sync, or !en, or sync.
  - Action: fcw[c] <= shadow_fcw[c], pow[c] <= shadow_pow[c], pending[c] <= 0.
  - The increment on the commit cycle uses the old fcw; the new fcw applies from the next increment. This makes the update phase-continuous.
  - A transfer and a commit are never on the same cycle, because cfg_ready = 0 while pending.
- Output:
  - pa_out[c] <= (acc[c] + pow[c])[NBIT-1 -: OBIT], registered.
  - One cycle of latency from the acc register.
  - POW changes take effect at commit with no further delay beyond this register.
- Width:
  - All additions are modulo 2^NBIT; carry is kept only for wrap.
  - fcw = 0 is legal: the accumulator holds and wrap stays 0.
- rst_n asserted mid-operation: everything returns to reset values immediately, and any pending update is lost.

Optional Feature:
- Macro: PA_DITHER_EN.
- Defined:
  - A shared 16-bit Fibonacci LFSR with taps 16,14,13,11 is added, seeded to 16'hACE1 on reset.
  - The LFSR advances every cycle en = 1.
  - Its low (NBIT-OBIT) bits are added to acc+pow before truncation, modulo 2^NBIT.
  - If NBIT == OBIT, dither is inert.
  - wrap is unaffected by the dither.
- Undefined: pure truncation, and no LFSR logic is present.

Test Plan:
- Reset and basic count (NBIT=12, OBIT=10):
  - Stimulus: rst_n low 36 cycles; then cfg ch0 fcw=2 while en=0 (immediate commit); then en=1.
  - Response: pa_out[0] = 0 during reset. Once en=1, acc0 = 0,2,4,…; pa_out[0] increments by 1 every 2 cycles. wrap[0] pulses once per 2048 cycles.
- Phase-continuous update:
  - Stimulus: ch1 fcw=256, en=1, then transfer fcw=512 mid-period.
  - Response: cfg_ready = 0 until ch1 wraps. Increments are 256 up to and including the wrap cycle, then 512. cfg_ready = 1 one cycle after commit.
- Phase offset:
  - Stimulus: ch2 fcw=0, pow=12'h800, committed while en=0.
  - Response: pa_out[2] = 10'h200, constant. The other channels are unaffected.
- Sync priority:
  - Stimulus: all channels running; assert sync with en=1 for one cycle.
  - Response: all acc = 0 next cycle; wrap = 0 on that cycle; pending updates commit.
- Handshake backpressure:
  - Stimulus: hold cfg_valid high with cfg_ch=3 for two words back-to-back, en=1.
  - Response: second word accepted only after ch3 commits; never two transfers while pending.
- Async reset mid-update:
  - Stimulus: assert rst_n low while pending[0] = 1.
  - Response: all outputs reset within the same cycle; pending cleared; cfg_ready = 1.

Source files
------------

// File: rtl/pa_mc.sv
// pa_mc: NCH-channel phase accumulator with shadowed FCW/POW that commit at each channel's wrap.
// Optional LFSR dither ahead of truncation is enabled by defining PA_DITHER_EN.
module pa_mc #(
    parameter int NBIT = 12,
    parameter int OBIT = 10,
    parameter int NCH  = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [NBIT-1:0]     fcw_in,
    input  logic [NBIT-1:0]     pow_in,
    output logic [NCH*OBIT-1:0] pa_out,
    output logic [NCH-1:0]      wrap
);

    logic [NBIT-1:0] acc        [NCH];
    logic [NBIT-1:0] fcw        [NCH];
    logic [NBIT-1:0] pow        [NCH];
    logic [NBIT-1:0] shadow_fcw [NCH];
    logic [NBIT-1:0] shadow_pow [NCH];
    logic [NBIT-1:0] acc_next   [NCH];
    logic [NBIT-1:0] phase      [NCH];
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  pending_next;
    logic [NCH-1:0]  carry;
    logic [NCH-1:0]  commit;
    logic [NCH-1:0]  load;
    logic [NBIT-1:0] dither;
    logic            xfer;

    // Config handshake: a word moves on every cycle with cfg_valid && cfg_ready; cfg_ready is
    // low while any channel holds an uncommitted word, so at most one update is ever in flight.
    assign xfer = cfg_valid && cfg_ready;

`ifdef PA_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (en) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        dither = '0;
        for (int i = 0; i < NBIT - OBIT && i < 16; i++) begin
            dither[i] = lfsr[i];
        end
    end
`else
    assign dither = '0;
`endif

    // Commit waits for the carry so the new FCW starts exactly at a period boundary.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            {carry[c], acc_next[c]} = {1'b0, acc[c]} + {1'b0, fcw[c]};
            phase[c]        = acc[c] + pow[c] + dither;
            load[c]         = xfer && (cfg_ch == CHW'(c));
            commit[c]       = pending[c] && (sync || !en || carry[c]);
            pending_next[c] = load[c] || (pending[c] && !commit[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c]        <= '0;
                fcw[c]        <= '0;
                pow[c]        <= '0;
                shadow_fcw[c] <= '0;
                shadow_pow[c] <= '0;
            end
            pending   <= '0;
            wrap      <= '0;
            pa_out    <= '0;
            cfg_ready <= 1'b1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (sync) begin
                    acc[c]  <= '0;
                    wrap[c] <= 1'b0;
                end else if (en) begin
                    acc[c]  <= acc_next[c];
                    wrap[c] <= carry[c];
                end else begin
                    wrap[c] <= 1'b0;
                end
                if (commit[c]) begin
                    fcw[c] <= shadow_fcw[c];
                    pow[c] <= shadow_pow[c];
                end
                if (load[c]) begin
                    shadow_fcw[c] <= fcw_in;
                    shadow_pow[c] <= pow_in;
                end
                pa_out[c*OBIT +: OBIT] <= phase[c][NBIT-1 -: OBIT];
            end
            pending   <= pending_next;
            cfg_ready <= ~|pending_next;
        end
    end

endmodule

// File: tb/tb_pa_mc.sv
// tb_pa_mc: vector table plus hand sequences for pa_mc, with a cycle model feeding a scoreboard queue.
module tb_pa_mc;
    localparam int NBIT = 12;
    localparam int OBIT = 10;
    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int W    = NCH*OBIT + NCH + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                sync = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [CHW-1:0]      cfg_ch = '0;
    logic [NBIT-1:0]     fcw_in = '0;
    logic [NBIT-1:0]     pow_in = '0;
    logic                cfg_ready;
    logic [NCH*OBIT-1:0] pa_out;
    logic [NCH-1:0]      wrap;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic last_xfer = 1'b0;

    // reference state
    logic [NBIT-1:0]     m_acc  [NCH];
    logic [NBIT-1:0]     m_fcw  [NCH];
    logic [NBIT-1:0]     m_pow  [NCH];
    logic [NBIT-1:0]     m_sfcw [NCH];
    logic [NBIT-1:0]     m_spow [NCH];
    logic [NCH-1:0]      m_pend;
    logic                m_ready;
    logic [NCH*OBIT-1:0] m_pa;
    logic [NCH-1:0]      m_wrap;

    pa_mc #(.NBIT(NBIT), .OBIT(OBIT), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .fcw_in(fcw_in), .pow_in(pow_in), .pa_out(pa_out), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want test end");
        bad++;
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [OBIT-1:0] pa_ch(input int c);
        return pa_out[c*OBIT +: OBIT];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0; m_fcw[c] = '0; m_pow[c] = '0; m_sfcw[c] = '0; m_spow[c] = '0;
        end
        m_pend = '0; m_ready = 1'b1; m_pa = '0; m_wrap = '0;
        exp_q.delete();
    endtask

    // Advances the reference by one clock using the inputs currently driven.
    task automatic model_step();
        logic [NBIT:0]   s;
        logic [NBIT-1:0] ph;
        logic            xfer;
        logic            cmt;
        xfer = cfg_valid && m_ready;
        for (int c = 0; c < NCH; c++) begin
            s  = {1'b0, m_acc[c]} + {1'b0, m_fcw[c]};
            ph = m_acc[c] + m_pow[c];
            m_pa[c*OBIT +: OBIT] = ph[NBIT-1 -: OBIT];
            cmt = m_pend[c] && (sync || !en || s[NBIT]);
            if (sync) begin
                m_acc[c] = '0; m_wrap[c] = 1'b0;
            end else if (en) begin
                m_acc[c] = s[NBIT-1:0]; m_wrap[c] = s[NBIT];
            end else begin
                m_wrap[c] = 1'b0;
            end
            if (cmt) begin
                m_fcw[c] = m_sfcw[c]; m_pow[c] = m_spow[c]; m_pend[c] = 1'b0;
            end
            if (xfer && int'(cfg_ch) == c) begin
                m_sfcw[c] = fcw_in; m_spow[c] = pow_in; m_pend[c] = 1'b1;
            end
        end
        m_ready = ~|m_pend;
        exp_q.push_back({m_pa, m_wrap, m_ready});
    endtask

    task automatic sb_check();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got no expected entry want one");
        end else begin
            e = exp_q.pop_front();
            check("sb_pa_out", pa_out, e[W-1 -: NCH*OBIT]);
            check("sb_wrap", wrap, e[NCH:1]);
            check("sb_cfg_ready", cfg_ready, e[0]);
        end
    endtask

    task automatic step(input logic e, input logic s, input logic v, input int ch,
                        input logic [NBIT-1:0] f, input logic [NBIT-1:0] p);
        @(negedge clk);
        en = e; sync = s; cfg_valid = v; cfg_ch = CHW'(ch); fcw_in = f; pow_in = p;
        last_xfer = cfg_valid && cfg_ready;
        model_step();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    typedef struct {
        logic            e, s, v;
        int              ch;
        logic [NBIT-1:0] f, p;
        logic            rdy;
        logic [OBIT-1:0] pa0, pa2;
    } vec_t;

    vec_t vecs[13];
    int   n;
    logic got;

    initial begin
        // e  s  v  ch  fcw    pow     rdy  pa0  pa2
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 0, 12'd2,   12'h000, 1'b0, 10'd0, 10'h000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd0, 10'h000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2, 12'd0,   12'h800, 1'b0, 10'd0, 10'h000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd0, 10'h000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd0, 10'h200};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd0, 10'h200};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd1, 10'h200};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd1, 10'h200};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd2, 10'h200};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1, 12'd256, 12'h000, 1'b0, 10'd2, 10'h200};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd2, 10'h200};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd2, 10'h200};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 0, 12'd0,   12'h000, 1'b1, 10'd0, 10'h200};

        // reset held for 36 cycles
        model_reset();
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (i % 12 == 11) begin
                check("rst_pa_out", pa_out, 0);
                check("rst_wrap", wrap, 0);
                check("rst_cfg_ready", cfg_ready, 1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;

        // count, offset and sync vectors
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].e, vecs[i].s, vecs[i].v, vecs[i].ch, vecs[i].f, vecs[i].p);
            check($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].rdy);
            check($sformatf("vec%0d_pa0", i), pa_ch(0), vecs[i].pa0);
            check($sformatf("vec%0d_pa2", i), pa_ch(2), vecs[i].pa2);
            check($sformatf("vec%0d_wrap", i), wrap, 0);
        end

        // phase-continuous FCW change on ch1 (256 -> 512)
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        step(1'b1, 1'b0, 1'b1, 1, 12'd512, 12'd0);
        check("pc_ready_low", cfg_ready, 0);
        n = 0; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
            n++;
            if (cfg_ready) got = 1'b1;
        end
        check("pc_cycles_to_ready", n, 13);
        check("pc_wrap1", wrap[1], 1);
        check("pc_pa1_wrapcycle", pa_ch(1), 10'h3C0);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("pc_pa1_a", pa_ch(1), 10'h000);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("pc_pa1_b", pa_ch(1), 10'h080);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("pc_pa1_c", pa_ch(1), 10'h100);

        // backpressure on ch3: two words back-to-back
        step(1'b0, 1'b0, 1'b1, 3, 12'd1024, 12'd0);
        step(1'b0, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        step(1'b1, 1'b0, 1'b1, 3, 12'd2048, 12'd0);
        check("bp_word1_taken", last_xfer, 1);
        n = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b1, 1'b0, 1'b1, 3, 12'd1024, 12'h400);
            n++;
            if (last_xfer) got = 1'b1;
        end
        check("bp_word2_cycles", n, 4);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("bp_wrap3", wrap[3], 1);
        check("bp_pa3_a", pa_ch(3), 10'h200);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("bp_pa3_b", pa_ch(3), 10'h100);
        check("bp_wrap3_clear", wrap[3], 0);

        // sync with an update pending on ch0
        step(1'b1, 1'b0, 1'b1, 0, 12'd6, 12'd0);
        check("sy_pending", cfg_ready, 0);
        step(1'b1, 1'b1, 1'b0, 0, 12'd0, 12'd0);
        check("sy_ready", cfg_ready, 1);
        check("sy_wrap", wrap, 0);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("sy_pa_all", pa_out, {10'h100, 10'h200, 10'h000, 10'h000});
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("sy_pa0_newfcw", pa_ch(0), 10'd1);

        // async reset while ch0 update is pending
        step(1'b1, 1'b0, 1'b1, 0, 12'd100, 12'd0);
        step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("ar_pending", cfg_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pa_out", pa_out, 0);
        check("ar_wrap", wrap, 0);
        check("ar_ready", cfg_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 12'd0, 12'd0);
        check("ar_pa_after", pa_out, 0);
        check("ar_ready_after", cfg_ready, 1);

        // random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
